// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and defaults for the SRAM-like request arbiter.
//   owner_e     : which requester owns an accepted transaction (0 = inst, 1 = data)
//   arb_state_e : arbiter FSM state, also exported on the top's debug port
//   DEF_DEPTH / DEF_STARVE_LIM : default parameter values
package sram_arb_pkg;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_STARVE_LIM = 4;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// owner_fifo: in-order record of which requester owns each accepted,
// not-yet-answered transaction. One bit wide, DEPTH entries.
//   clk, rst : clock, synchronous active-high reset
//   push, din: write din at the tail
//   pop      : drop the head entry
//   head     : owner at the head (valid when !empty)
//   count    : number of stored entries, 0..DEPTH
//   full, empty
module owner_fifo
  import sram_arb_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  owner_e        din,
  input  logic          pop,
  output owner_e        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  owner_e        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= OWN_INST;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like master port between the inst and
// data SRAM-like requesters. Data wins arbitration unless inst has watched
// STARVE_LIM consecutive data acceptances while waiting. Every accepted
// request's owner goes into an in-order FIFO so responses are steered back.
//
// Handshake: a requester's req is its valid and *_addr_ok its ready; a
// request transfers in the cycle both are high, and all request fields stay
// stable from req rising until that cycle. *_data_ok is a one-cycle response
// pulse with no backpressure; responses return in acceptance order.
//
// Ports:
//   aclk, aresetn            : clock, synchronous reset (active-high despite the name)
//   inst_sram_* / data_sram_*: requester sides (req, wr, size, wstrb, addr, wdata in;
//                              addr_ok, data_ok, rdata out)
//   m_*                      : master side towards the bridge
//   resp_err                 : sticky, response arrived with nothing outstanding
//   state, cnt               : debug view of FSM state and outstanding count
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int  DEPTH      = DEF_DEPTH,
  parameter int  STARVE_LIM = DEF_STARVE_LIM,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int SW         = $clog2(STARVE_LIM + 1)
) (
  input  logic          aclk,
  input  logic          aresetn,
  // instruction requester
  input  logic          inst_sram_req,
  input  logic          inst_sram_wr,
  input  logic [2:0]    inst_sram_size,
  input  logic [3:0]    inst_sram_wstrb,
  input  logic [31:0]   inst_sram_addr,
  input  logic [31:0]   inst_sram_wdata,
  output logic          inst_sram_addr_ok,
  output logic          inst_sram_data_ok,
  output logic [31:0]   inst_sram_rdata,
  // data requester
  input  logic          data_sram_req,
  input  logic          data_sram_wr,
  input  logic [2:0]    data_sram_size,
  input  logic [3:0]    data_sram_wstrb,
  input  logic [31:0]   data_sram_addr,
  input  logic [31:0]   data_sram_wdata,
  output logic          data_sram_addr_ok,
  output logic          data_sram_data_ok,
  output logic [31:0]   data_sram_rdata,
  // master port
  output logic          m_req,
  output logic          m_wr,
  output logic [2:0]    m_size,
  output logic [3:0]    m_wstrb,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  input  logic          m_addr_ok,
  input  logic          m_data_ok,
  input  logic [31:0]   m_rdata,
  // status / debug
  output logic          resp_err,
  output arb_state_e    state,
  output logic [CW-1:0] cnt
);

  logic [SW-1:0] starve;
  logic          starve_hit;
  logic          fifo_full;
  logic          fifo_empty;
  owner_e        head;
  owner_e        push_owner;
  logic          push;
  logic          pop;

  assign starve_hit = (starve == SW'(STARVE_LIM));

  // Acceptance happens only while a grant is held.
  assign push       = m_addr_ok && (state != IDLE);
  assign push_owner = (state == GNT_D) ? OWN_DATA : OWN_INST;
  assign pop        = m_data_ok && !fifo_empty;

  assign inst_sram_addr_ok = m_addr_ok && (state == GNT_I);
  assign data_sram_addr_ok = m_addr_ok && (state == GNT_D);

  assign inst_sram_data_ok = pop && (head == OWN_INST);
  assign data_sram_data_ok = pop && (head == OWN_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? m_rdata : 32'h0;
  assign data_sram_rdata   = data_sram_data_ok ? m_rdata : 32'h0;

  // Master fields follow the granted requester; zero while idle.
  always_comb begin
    m_wr    = 1'b0;
    m_size  = 3'd0;
    m_wstrb = 4'd0;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    unique case (state)
      GNT_I: begin
        m_wr    = inst_sram_wr;
        m_size  = inst_sram_size;
        m_wstrb = inst_sram_wstrb;
        m_addr  = inst_sram_addr;
        m_wdata = inst_sram_wdata;
      end
      GNT_D: begin
        m_wr    = data_sram_wr;
        m_size  = data_sram_size;
        m_wstrb = data_sram_wstrb;
        m_addr  = data_sram_addr;
        m_wdata = data_sram_wdata;
      end
      default: ;
    endcase
  end

  // Arbiter FSM. m_req is registered alongside the state so it rises the
  // cycle after a request is seen in IDLE. The full check uses the count
  // before any pop this cycle, so a draining slot is only reused next cycle.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state  <= IDLE;
      m_req  <= 1'b0;
      starve <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_full) begin
            if (data_sram_req && !(inst_sram_req && starve_hit)) begin
              state <= GNT_D;
              m_req <= 1'b1;
            end else if (inst_sram_req) begin
              state <= GNT_I;
              m_req <= 1'b1;
            end
          end
        end
        GNT_I: begin
          if (m_addr_ok) begin
            state  <= IDLE;
            m_req  <= 1'b0;
            starve <= '0;
          end
        end
        GNT_D: begin
          if (m_addr_ok) begin
            state <= IDLE;
            m_req <= 1'b0;
            // Count only data wins that made a waiting inst request wait.
            if (inst_sram_req && !starve_hit) starve <= starve + SW'(1);
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) resp_err <= 1'b0;
    else if (m_data_ok && fifo_empty) resp_err <= 1'b1;
  end

  owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
    .clk   (aclk),
    .rst   (aresetn),
    .push  (push),
    .din   (push_owner),
    .pop   (pop),
    .head  (head),
    .count (cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  localparam int W = 33; // {owner, rdata}
  localparam logic [31:0] I_ADDR = 32'h1000_0000;
  localparam logic [31:0] D_ADDR = 32'h2000_0000;

  logic        aclk;
  logic        aresetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [2:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [2:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        m_req, m_wr;
  logic [2:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        resp_err;
  arb_state_e  state;
  logic [2:0]  cnt;

  logic [W-1:0] exp_q[$];
  int tests_run;
  int tests_failed;

  sram_req_arbiter #(.DEPTH(4), .STARVE_LIM(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .resp_err(resp_err), .state(state), .cnt(cnt)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 3'd2; inst_sram_wstrb = 0;
    inst_sram_addr = I_ADDR; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 3'd2; data_sram_wstrb = 0;
    data_sram_addr = D_ADDR; data_sram_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1;
    repeat (2) @(posedge aclk);
    #2;
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
    tests_run++; if ({m_wr, m_size, m_wstrb, m_addr, m_wdata} !== '0) begin tests_failed++; $display("FAIL reset_m_fields: got addr %h wdata %h expected 0", m_addr, m_wdata); end
    tests_run++; if ({inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok} !== 4'b0) begin tests_failed++; $display("FAIL reset_oks: got nonzero expected 0"); end
    tests_run++; if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h %h expected 0", inst_sram_rdata, data_sram_rdata); end
    tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    tests_run++; if (state !== IDLE || cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_state_cnt: got %0d/%0d expected IDLE/0", state, cnt); end
    @(posedge aclk); #1;
    aresetn = 0;
  endtask

  task automatic test_single_inst_read();
    logic [W-1:0] e;
    @(posedge aclk); #1; // cycle 0
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    #1;
    tests_run++; if (m_req !== 1'b0) begin tests_failed++; $display("FAIL single_c0_m_req: got %b expected 0", m_req); end
    @(posedge aclk); #2; // cycle 1
    tests_run++; if (m_req !== 1'b1 || m_addr !== 32'h1C00_0000) begin tests_failed++; $display("FAIL single_c1_grant: got req %b addr %h expected 1 1c000000", m_req, m_addr); end
    tests_run++; if (inst_sram_addr_ok !== 1'b0) begin tests_failed++; $display("FAIL single_c1_addr_ok: got %b expected 0", inst_sram_addr_ok); end
    @(posedge aclk); #1; // cycle 2
    m_addr_ok = 1;
    #1;
    tests_run++; if (m_req !== 1'b1 || inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin tests_failed++; $display("FAIL single_c2_accept: got req %b iok %b dok %b expected 1 1 0", m_req, inst_sram_addr_ok, data_sram_addr_ok); end
    @(posedge aclk); #1; // cycle 3
    m_addr_ok = 0; inst_sram_req = 0;
    #1;
    tests_run++; if (m_req !== 1'b0 || cnt !== 3'd1) begin tests_failed++; $display("FAIL single_c3_idle: got req %b cnt %0d expected 0 1", m_req, cnt); end
    @(posedge aclk); #1; // cycle 4
    m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
    exp_q.push_back({OWN_INST, 32'hDEAD_BEEF});
    #1;
    e = exp_q.pop_front();
    tests_run++; if (inst_sram_data_ok !== ~e[32] || data_sram_data_ok !== e[32]) begin tests_failed++; $display("FAIL single_c4_data_ok: got i %b d %b expected inst", inst_sram_data_ok, data_sram_data_ok); end
    tests_run++; if (inst_sram_rdata !== e[31:0] || data_sram_rdata !== 32'h0) begin tests_failed++; $display("FAIL single_c4_rdata: got i %h d %h expected %h 0", inst_sram_rdata, data_sram_rdata, e[31:0]); end
    @(posedge aclk); #1;
    m_data_ok = 0;
    #1;
    tests_run++; if (cnt !== 3'd0) begin tests_failed++; $display("FAIL single_cnt_after: got %0d expected 0", cnt); end
  endtask

  task automatic test_starvation();
    logic       pend;
    logic       pend_own;
    logic [W-1:0] e;
    logic [3:0] order [10];
    order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++) exp_q.push_back({order[i][0], 32'h0});
    pend = 0; pend_own = 0;
    inst_sram_addr = I_ADDR; data_sram_addr = D_ADDR;
    for (int cyc = 0; cyc < 80 && (exp_q.size() != 0 || pend); cyc++) begin
      @(posedge aclk); #1;
      inst_sram_req = (exp_q.size() != 0);
      data_sram_req = (exp_q.size() != 0);
      m_addr_ok = 1;
      m_data_ok = pend;
      m_rdata = $urandom;
      #1;
      if (pend) begin
        tests_run++;
        if (data_sram_data_ok !== pend_own || inst_sram_data_ok !== ~pend_own ||
            (pend_own ? data_sram_rdata : inst_sram_rdata) !== m_rdata ||
            (pend_own ? inst_sram_rdata : data_sram_rdata) !== 32'h0) begin
          tests_failed++;
          $display("FAIL starve_resp_route: got i %b d %b expected owner %b", inst_sram_data_ok, data_sram_data_ok, pend_own);
        end
      end
      pend = 0;
      if (inst_sram_addr_ok || data_sram_addr_ok) begin
        e = exp_q.pop_front();
        tests_run++;
        if (data_sram_addr_ok !== e[32] || inst_sram_addr_ok !== ~e[32]) begin
          tests_failed++;
          $display("FAIL starve_order: got d %b i %b expected owner %b (left %0d)", data_sram_addr_ok, inst_sram_addr_ok, e[32], exp_q.size());
        end
        tests_run++;
        if (m_addr !== (e[32] ? D_ADDR : I_ADDR)) begin
          tests_failed++;
          $display("FAIL starve_m_addr: got %h expected %h", m_addr, e[32] ? D_ADDR : I_ADDR);
        end
        pend = 1; pend_own = e[32];
      end
    end
    tests_run++;
    if (exp_q.size() != 0 || pend) begin
      tests_failed++;
      $display("FAIL starve_timeout: got %0d grants left expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge aclk); #1;
    idle_inputs();
  endtask

  task automatic test_interleave();
    logic got;
    logic [W-1:0] e;
    @(posedge aclk); #1;
    data_sram_req = 1; data_sram_wr = 1; data_sram_wstrb = 4'hF;
    data_sram_addr = 32'h3000_0004; data_sram_wdata = 32'h55AA_33CC;
    m_addr_ok = 1;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge aclk); #2;
      if (data_sram_addr_ok) got = 1;
    end
    tests_run++; if (!got) begin tests_failed++; $display("FAIL inter_data_accept: got none expected data_addr_ok"); end
    tests_run++; if (m_wr !== 1'b1 || m_wstrb !== 4'hF || m_wdata !== 32'h55AA_33CC || m_addr !== 32'h3000_0004 || m_size !== 3'd2) begin tests_failed++; $display("FAIL inter_data_fields: got wr %b strb %h wdata %h addr %h", m_wr, m_wstrb, m_wdata, m_addr); end
    exp_q.push_back({OWN_DATA, 32'h0000_0001});
    @(posedge aclk); #1;
    data_sram_req = 0; data_sram_wr = 0;
    inst_sram_req = 1; inst_sram_wr = 0; inst_sram_addr = 32'h1C00_0040;
    got = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(posedge aclk); #2;
      if (inst_sram_addr_ok) got = 1;
    end
    tests_run++; if (!got || m_wr !== 1'b0 || m_addr !== 32'h1C00_0040) begin tests_failed++; $display("FAIL inter_inst_accept: got ok %b wr %b addr %h expected 1 0 1c000040", got, m_wr, m_addr); end
    exp_q.push_back({OWN_INST, 32'hCAFE_F00D});
    @(posedge aclk); #1;
    inst_sram_req = 0; m_addr_ok = 0;
    for (int r = 0; r < 2; r++) begin
      @(posedge aclk); #1;
      e = exp_q[0];
      m_data_ok = 1; m_rdata = e[31:0];
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (inst_sram_data_ok !== ~e[32] || data_sram_data_ok !== e[32] ||
          inst_sram_rdata !== (e[32] ? 32'h0 : e[31:0]) || data_sram_rdata !== (e[32] ? e[31:0] : 32'h0)) begin
        tests_failed++;
        $display("FAIL inter_resp_%0d: got i %b/%h d %b/%h expected owner %b data %h", r, inst_sram_data_ok, inst_sram_rdata, data_sram_data_ok, data_sram_rdata, e[32], e[31:0]);
      end
    end
    @(posedge aclk); #1;
    m_data_ok = 0;
  endtask

  task automatic test_full();
    int acc;
    logic [W-1:0] e;
    @(posedge aclk); #1;
    data_sram_req = 1; data_sram_addr = 32'h2000_0100; m_addr_ok = 1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge aclk); #2;
      if (data_sram_addr_ok) begin
        acc++;
        exp_q.push_back({OWN_DATA, 32'hA000_0000 + 32'(acc)});
      end
    end
    tests_run++; if (acc != 4 || cnt !== 3'd4) begin tests_failed++; $display("FAIL full_accepts: got %0d cnt %0d expected 4 4", acc, cnt); end
    tests_run++; if (m_req !== 1'b0 || state !== IDLE) begin tests_failed++; $display("FAIL full_stall: got req %b state %0d expected 0 IDLE", m_req, state); end
    @(posedge aclk); #1;
    m_data_ok = 1; m_rdata = exp_q[0][31:0];
    #1;
    e = exp_q.pop_front();
    tests_run++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== e[31:0]) begin tests_failed++; $display("FAIL full_pop: got %b %h expected 1 %h", data_sram_data_ok, data_sram_rdata, e[31:0]); end
    @(posedge aclk); #1;
    m_data_ok = 0;
    #1;
    tests_run++; if (m_req !== 1'b0 || cnt !== 3'd3) begin tests_failed++; $display("FAIL full_no_same_cycle_grant: got req %b cnt %0d expected 0 3", m_req, cnt); end
    @(posedge aclk); #2;
    tests_run++; if (m_req !== 1'b1 || data_sram_addr_ok !== 1'b1) begin tests_failed++; $display("FAIL full_regrant: got req %b ok %b expected 1 1", m_req, data_sram_addr_ok); end
    exp_q.push_back({OWN_DATA, 32'hA000_0005});
    @(posedge aclk); #1;
    data_sram_req = 0; m_addr_ok = 0;
    for (int r = 0; r < 4; r++) begin
      @(posedge aclk); #1;
      m_data_ok = 1; m_rdata = exp_q[0][31:0];
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (data_sram_data_ok !== 1'b1 || inst_sram_data_ok !== 1'b0 || data_sram_rdata !== e[31:0]) begin
        tests_failed++;
        $display("FAIL full_drain_%0d: got %b %h expected 1 %h", r, data_sram_data_ok, data_sram_rdata, e[31:0]);
      end
    end
    @(posedge aclk); #1;
    m_data_ok = 0;
    #1;
    tests_run++; if (cnt !== 3'd0) begin tests_failed++; $display("FAIL full_drained_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_resp_err();
    @(posedge aclk); #1;
    m_data_ok = 1; m_rdata = 32'h1234_5678;
    #1;
    tests_run++; if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0 || inst_sram_rdata !== 32'h0 || data_sram_rdata !== 32'h0) begin tests_failed++; $display("FAIL err_no_data_ok: got i %b d %b expected 0 0", inst_sram_data_ok, data_sram_data_ok); end
    @(posedge aclk); #1;
    m_data_ok = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (resp_err !== 1'b1 || cnt !== 3'd0) begin tests_failed++; $display("FAIL err_sticky_%0d: got %b cnt %0d expected 1 0", c, resp_err, cnt); end
      @(posedge aclk); #1;
    end
    aresetn = 1;
    @(posedge aclk); #1;
    aresetn = 0;
    #1;
    tests_run++; if (resp_err !== 1'b0 || cnt !== 3'd0 || state !== IDLE || m_req !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got err %b cnt %0d state %0d expected 0 0 IDLE", resp_err, cnt, state); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    aresetn = 1;
    idle_inputs();
    test_reset();
    test_single_inst_read();
    test_starvation();
    test_interleave();
    test_full();
    test_resp_err();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
